seq_mult_nxn: RTL and testbench
===============================

# seq_mult_nxn

Parametrised sequential multiplier: the next generation of the 8x8 digit-serial multiplier. It splits two WIDTH-bit operands into DIGIT-bit digits and accumulates one shifted digit partial product per clock. It adds a signed/unsigned mode, a busy/done handshake and a product register that holds its value during computation. It sits between operand registers and a result consumer, and exports a 3-bit state code for the seven-segment status decoder.

## Interface

Parameters:
- WIDTH, 8, operand width in bits. Must be a multiple of DIGIT; any other value is an elaboration error.
- DIGIT, 4, digit width in bits. Sets the width of the internal DIGITxDIGIT multiplier. N = WIDTH/DIGIT, and N must be at least 1.

Ports:
- clk  in  1  single clock; everything updates on the rising edge.
- aclr_n  in  1  asynchronous, active-low reset.
- start  in  1  request to start; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured when start is accepted.
- dataa  in  WIDTH  multiplicand; captured when start is accepted.
- datab  in  WIDTH  multiplier; captured when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; high in DONE only.
- product  out  2*WIDTH  last completed result; held until the next completion.
- state_out  out  3  IDLE=0, CALC=1, FIX=2, DONE=3; codes 4-7 are unused.

## Operation

State machine:
- IDLE: if start=1, capture operands, go to CALC. Otherwise stay.
- CALC: lasts N*N cycles. Exits to FIX after the last partial product.
- FIX: lasts 1 cycle. Writes the product register and goes to DONE.
- DONE: lasts 1 cycle. Goes to IDLE unconditionally.

Capture at start acceptance:
- Signed mode: store the magnitudes |dataa| and |datab| as WIDTH-bit unsigned values, and store neg = sign(dataa) XOR sign(datab). The most negative input (-2^(WIDTH-1)) has magnitude 2^(WIDTH-1), which fits in WIDTH bits.
- Unsigned mode: store the operands unchanged, neg=0.
- Clear the 2*WIDTH-bit accumulator and the digit indices i and j.

CALC:
- Each cycle: acc += (a_digit[i] * b_digit[j]) << (DIGIT*(i+j)). All arithmetic is 2*WIDTH bits; the unsigned sum of magnitudes cannot overflow.
- j increments every cycle. When j wraps from N-1 to 0, i increments.
- The exit condition is i=N-1 and j=N-1.

FIX:
- product <= neg ? -acc : acc, in 2*WIDTH-bit two's complement.
- A zero result is written as 0 (no negative zero).

General rules:
- product changes only on the FIX->DONE edge and on reset. The accumulator is never visible on product.
- start is ignored in CALC, FIX and DONE. Operand or signed_mode changes during busy have no effect.
- start held high continuously causes back-to-back operations. Each one recaptures the operands present on its accept edge.

Reset (aclr_n low, at any time, including mid-operation):
- state=IDLE, state_out=0, busy=0, done=0, product=0.
- The accumulator, i, j, neg and captured operands are all cleared.
- The operation in progress is discarded without any done pulse.

## Timing

- Accept edge k: start=1 sampled in IDLE.
- Edges k+1 .. k+N*N: one partial product per edge. Edge k+N*N enters FIX.
- Edge k+N*N+1: product updated, done=1.
- Edge k+N*N+2: done=0, back to IDLE.
- busy is high from after edge k until edge k+N*N+2.
- Minimum start-to-start period is N*N+3 cycles: 7 for the default, 19 for WIDTH=16, DIGIT=4.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset deassertion is synchronised externally. The first edge after release may accept start.

## Test plan

- Default parameters, unsigned, dataa=0xFF, datab=0xFF, start pulse at edge k -> product=0xFE01 and done=1 after edge k+5. busy is high for 6 cycles; product holds its old value until then.
- Signed, dataa=0x80 (-128), datab=0x80 -> product=0x4000. Signed, dataa=0xFF (-1), datab=0x01 -> 0xFFFF. Signed, dataa=0x00, datab=0x85 -> 0x0000.
- Same bits in unsigned mode, dataa=0x80, datab=0xFF -> 0x7F80. In signed mode -> 0x0080.
- start held high for 20 cycles with the operands changed at each done -> accepts every 7 cycles, each result matches the operands at its own accept edge. The done pulses are exactly one cycle wide.
- aclr_n pulsed low at edge k+2 of an operation -> product=0, busy=0, done=0, state_out=0, and no done pulse. A following start with 3*5 -> 0x000F.
- WIDTH=16, DIGIT=4, unsigned 0xFFFF*0xFFFF -> 0xFFFE0001 with done after edge k+17. Signed 0x8000*0x7FFF -> 0xC0008000.

Source files
------------

// File: rtl/seq_mult_nxn.sv
// Digit-serial WIDTHxWIDTH multiplier: one DIGITxDIGIT partial product per clock,
// signed/unsigned operands, busy/done handshake and a held product register.
module seq_mult_nxn #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [2:0]           state_out
);

    localparam int unsigned N   = (DIGIT == 0) ? 0 : WIDTH / DIGIT;
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned DW2 = 2 * DIGIT;
    localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW  = $clog2(PW) + 1;

    if ((DIGIT == 0) || (WIDTH < DIGIT) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("seq_mult_nxn: WIDTH must be a non-zero multiple of DIGIT");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        FIX  = 3'd2,
        DONE = 3'd3
    } state_t;

    state_t              state, state_nxt;
    logic                capture, calc_en, fix_en;

    logic [WIDTH-1:0]    a_reg, b_reg;
    logic                neg;
    logic [PW-1:0]       acc;
    logic [IW-1:0]       i_idx, j_idx;

    logic [WIDTH-1:0]    a_mag, b_mag;
    logic                neg_in;
    logic [DIGIT-1:0]    a_dig, b_dig;
    logic [DW2-1:0]      pp;
    logic [SW-1:0]       shamt;
    logic [PW-1:0]       pp_sh;
    logic                last_pp;

    // Operand magnitudes; -2^(WIDTH-1) negates onto itself, which is its unsigned magnitude
    assign a_mag  = (signed_mode && dataa[WIDTH-1]) ? (~dataa + WIDTH'(1)) : dataa;
    assign b_mag  = (signed_mode && datab[WIDTH-1]) ? (~datab + WIDTH'(1)) : datab;
    assign neg_in = signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);

    assign a_dig   = a_reg[i_idx*DIGIT +: DIGIT];
    assign b_dig   = b_reg[j_idx*DIGIT +: DIGIT];
    assign pp      = DW2'(a_dig) * DW2'(b_dig);
    assign shamt   = SW'(DIGIT) * (SW'(i_idx) + SW'(j_idx));
    assign pp_sh   = PW'(pp) << shamt;
    assign last_pp = (i_idx == IW'(N - 1)) && (j_idx == IW'(N - 1));

    // State register plus registered status outputs decoded from the next state
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            state_out <= 3'd0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            state_out <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        calc_en   = 1'b0;
        fix_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                calc_en = 1'b1;
                if (last_pp) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                fix_en    = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, digit accumulation, sign fix-up into the product register
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
            product <= '0;
        end else begin
            if (capture) begin
                a_reg <= a_mag;
                b_reg <= b_mag;
                neg   <= neg_in;
                acc   <= '0;
                i_idx <= '0;
                j_idx <= '0;
            end else if (calc_en) begin
                acc <= acc + pp_sh;
                if (j_idx == IW'(N - 1)) begin
                    j_idx <= '0;
                    i_idx <= last_pp ? '0 : i_idx + IW'(1);
                end else begin
                    j_idx <= j_idx + IW'(1);
                end
            end
            if (fix_en) begin
                product <= neg ? (~acc + PW'(1)) : acc;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_nxn.sv
// Directed bench for seq_mult_nxn: default 8x8/4 instance and a 16x16/4 instance.
module tb_seq_mult_nxn;

    logic        clk;
    logic        aclr_n;

    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] product8;
    logic [2:0]  state8;

    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] product16;
    logic [2:0]  state16;

    int n_tests;
    int n_fail;
    logic [15:0] last8;
    logic [31:0] last16;

    seq_mult_nxn #(.WIDTH(8), .DIGIT(4)) u_dut8 (
        .clk(clk), .aclr_n(aclr_n), .start(start8), .signed_mode(sm8),
        .dataa(a8), .datab(b8), .busy(busy8), .done(done8),
        .product(product8), .state_out(state8)
    );

    seq_mult_nxn #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .aclr_n(aclr_n), .start(start16), .signed_mode(sm16),
        .dataa(a16), .datab(b16), .busy(busy16), .done(done16),
        .product(product16), .state_out(state16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation; expects done exactly 5 edges after the accept edge
    task automatic do_op8(input string tag, input logic sm, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp);
        int n;
        sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'h5A; b8 = 8'hC3; sm8 = ~sm;
        check({tag, "_busy_k"}, 64'(busy8), 64'd1);
        n = 0;
        while (!done8 && n < 40) begin
            check({tag, "_hold"}, 64'(product8), 64'(last8));
            tick();
            n++;
            if (n == 4) check({tag, "_st_fix"}, 64'(state8), 64'd2);
        end
        check({tag, "_lat"}, 64'(n), 64'd5);
        check({tag, "_prod"}, 64'(product8), 64'(exp));
        check({tag, "_st_done"}, 64'(state8), 64'd3);
        last8 = exp;
        tick();
        check({tag, "_done_w"}, 64'(done8), 64'd0);
        check({tag, "_busy_end"}, 64'(busy8), 64'd0);
    endtask

    task automatic do_op16(input string tag, input logic sm, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] exp);
        int n;
        sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        a16 = 16'h1234;
        n = 0;
        while (!done16 && n < 60) begin
            check({tag, "_hold"}, 64'(product16), 64'(last16));
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd17);
        check({tag, "_prod"}, 64'(product16), 64'(exp));
        last16 = exp;
        tick();
        check({tag, "_done_w"}, 64'(done16), 64'd0);
    endtask

    logic [7:0]  pa [3];
    logic [7:0]  pb [3];
    logic [15:0] pe [3];

    initial begin
        int idx;
        int last_done;
        logic prev_done;
        logic saw_done;

        n_tests = 0; n_fail = 0;
        last8 = '0; last16 = '0;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
        aclr_n = 1'b0;
        tick(); tick();
        check("rst_prod", 64'(product8), 64'd0);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_state", 64'(state8), 64'd0);
        check("rst_prod16", 64'(product16), 64'd0);
        aclr_n = 1'b1;

        do_op8("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        do_op8("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000);
        do_op8("s_ff_01", 1'b1, 8'hFF, 8'h01, 16'hFFFF);
        do_op8("s_00_85", 1'b1, 8'h00, 8'h85, 16'h0000);
        do_op8("u_80_ff", 1'b0, 8'h80, 8'hFF, 16'h7F80);
        do_op8("s_80_ff", 1'b1, 8'h80, 8'hFF, 16'h0080);

        // start held high: accepts at edges 1, 8, 15; done after 6, 13, 20
        pa[0] = 8'h12; pb[0] = 8'h34; pe[0] = 16'h03A8;
        pa[1] = 8'hFF; pb[1] = 8'h02; pe[1] = 16'h01FE;
        pa[2] = 8'h0A; pb[2] = 8'h0B; pe[2] = 16'h006E;
        sm8 = 1'b0; a8 = pa[0]; b8 = pb[0]; start8 = 1'b1;
        idx = 0; last_done = 0; prev_done = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (prev_done) check("b2b_done_w", 64'(done8), 64'd0);
            if (done8 && idx < 3) begin
                check("b2b_prod", 64'(product8), 64'(pe[idx]));
                check("b2b_period", 64'(c - last_done), (idx == 0) ? 64'd6 : 64'd7);
                last_done = c;
                idx++;
                if (idx < 3) begin a8 = pa[idx]; b8 = pb[idx]; end
            end
            prev_done = done8;
        end
        start8 = 1'b0;
        check("b2b_count", 64'(idx), 64'd3);
        last8 = pe[2];
        tick(); tick();

        // reset mid-operation after edge k+2
        sm8 = 1'b0; a8 = 8'h55; b8 = 8'h66; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        aclr_n = 1'b0;
        #2;
        check("arst_prod", 64'(product8), 64'd0);
        check("arst_busy", 64'(busy8), 64'd0);
        check("arst_done", 64'(done8), 64'd0);
        check("arst_state", 64'(state8), 64'd0);
        aclr_n = 1'b1;
        last8 = '0;
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done8) saw_done = 1'b1;
        end
        check("arst_no_done", 64'(saw_done), 64'd0);
        do_op8("u_3_5", 1'b0, 8'd3, 8'd5, 16'h000F);

        do_op16("w16_u_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        do_op16("w16_s_8000", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000);
        do_op16("w16_s_m1m1", 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
